// File: rtl/inst_rom.sv
// Instruction memory: combinational fetch port plus a byte-serial big-endian loader.
// Optional trailing checksum byte per load session when INST_ROM_CHECKSUM_EN is defined.
module inst_rom #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           addr_i,
  output logic [31:0]           inst_o,
  input  logic                  ld_start_i,
  input  logic [ADDR_WIDTH-1:0] ld_base_i,
  input  logic [ADDR_WIDTH:0]   ld_len_i,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  output logic                  ld_ready_o,
  output logic                  ld_busy_o,
  output logic                  ld_done_o,
  output logic                  ld_err_o
);

  localparam int MEM_WORDS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef INST_ROM_CHECKSUM_EN
  localparam logic [1:0] S_CSUM = 2'd2;
  localparam logic [1:0] S_POST = S_CSUM;
`else
  localparam logic [1:0] S_POST = S_DONE;
`endif

  logic [31:0]           mem [0:MEM_WORDS-1];
  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH:0]   len_r;
  logic [ADDR_WIDTH:0]   wordcnt_r;
  logic [1:0]            bytecnt_r;
  logic [23:0]           asm_r;
  logic [ADDR_WIDTH:0]   len_sat;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  accept;
  logic                  word_wr;
  logic                  last_word;

`ifdef INST_ROM_CHECKSUM_EN
  logic [7:0] csum_r;
  logic       err_r;
`endif

  // Only the word-index bits of the fetch address matter.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  assign len_sat   = (ld_len_i > LEN_MAX) ? LEN_MAX : ld_len_i;
  assign last_word = (wordcnt_r + ONE_W) == len_r;
  assign waddr     = base_r + wordcnt_r[ADDR_WIDTH-1:0];

`ifdef INST_ROM_CHECKSUM_EN
  assign ld_ready_o = (state_r == S_RECV) || (state_r == S_CSUM);
  assign ld_err_o   = (state_r == S_DONE) && err_r;
`else
  assign ld_ready_o = (state_r == S_RECV);
  assign ld_err_o   = 1'b0;
`endif
  assign ld_busy_o = (state_r != S_IDLE);
  assign ld_done_o = (state_r == S_DONE);

  assign accept  = ld_valid_i & ld_ready_o;
  assign word_wr = accept && (state_r == S_RECV) && (bytecnt_r == 2'd3);

  // Fetch is masked while loading so the core never sees a half-written image.
  assign inst_o = (rst || !ce_i || ld_busy_o) ? 32'h0 : mem[addr_i[ADDR_WIDTH+1:2]];

  always_ff @(posedge clk) begin
    if (word_wr) mem[waddr] <= {asm_r, ld_byte_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      base_r    <= '0;
      len_r     <= '0;
      wordcnt_r <= '0;
      bytecnt_r <= '0;
      asm_r     <= '0;
`ifdef INST_ROM_CHECKSUM_EN
      csum_r    <= '0;
      err_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (ld_start_i) begin
            base_r    <= ld_base_i;
            len_r     <= len_sat;
            wordcnt_r <= '0;
            bytecnt_r <= '0;
            asm_r     <= '0;
`ifdef INST_ROM_CHECKSUM_EN
            csum_r    <= '0;
            err_r     <= 1'b0;
`endif
            state_r   <= (len_sat == '0) ? S_POST : S_RECV;
          end
        end
        S_RECV: begin
          if (accept) begin
            asm_r     <= {asm_r[15:0], ld_byte_i};
            bytecnt_r <= bytecnt_r + 2'd1;
`ifdef INST_ROM_CHECKSUM_EN
            csum_r    <= csum_r + ld_byte_i;
`endif
            if (bytecnt_r == 2'd3) begin
              wordcnt_r <= wordcnt_r + ONE_W;
              if (last_word) state_r <= S_POST;
            end
          end
        end
`ifdef INST_ROM_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            err_r   <= (ld_byte_i != csum_r);
            state_r <= S_DONE;
          end
        end
`endif
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule
